// File: rtl/tcs_pkg.sv
// ============================================================================
// Module   : tcs_pkg
// Purpose  : Shared types and helpers for the TCS3200 colour classifier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_C = 2'd3;

  // Returns {s2, s3} selecting the photodiode filter for a channel index.
  function automatic logic [1:0] s2s3_of(input logic [1:0] ch);
    case (ch)
      CH_R:    s2s3_of = 2'b00;
      CH_G:    s2s3_of = 2'b11;
      CH_B:    s2s3_of = 2'b01;
      default: s2s3_of = 2'b10;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcs_edge_counter.sv
// ============================================================================
// Module   : tcs_edge_counter
// Purpose  : Synchronises the sensor pin, detects rising edges and counts them
//            with saturation while enabled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tcs_edge_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sens_in,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  // pipe: [0] first sync stage, [1] second sync stage, [2] edge history
  logic [2:0]    pipe_q, pipe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_w;

  always_comb begin
    pipe_d = {pipe_q[1:0], sens_in};
    rise_w = pipe_q[1] & ~pipe_q[2];
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && rise_w && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/tcs_color_classifier.sv
// ============================================================================
// Module   : tcs_color_classifier
// Purpose  : TCS3200 front end: scans filter channels, counts edges per gate
//            window, classifies against threshold windows with N-frame confirm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tcs_color_classifier #(
  parameter int NCH        = 3,
  parameter int CW         = 9,
  parameter int GATE_CYC   = 300,
  parameter int SETTLE_CYC = 4,
  parameter int CONFIRM    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              sens_out,
  input  logic [NCH*CW-1:0] thr_lo,
  input  logic [NCH*CW-1:0] thr_hi,
  output logic              s2,
  output logic              s3,
  output logic              busy,
  output logic [CW-1:0]     raw_cnt,
  output logic [1:0]        raw_ch,
  output logic              raw_valid,
  output logic [2:0]        color,
  output logic              ambiguous,
  output logic              frame_done,
  output logic              color_valid
);

  import tcs_pkg::*;

  localparam int TW = $clog2(GATE_CYC + SETTLE_CYC + 1);
  localparam int RW = $clog2(CONFIRM + 1);
  localparam logic [TW-1:0] c_settle_last = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] c_gate_last   = TW'(GATE_CYC - 1);
  localparam logic [1:0]    c_last_ch     = 2'(NCH - 1);
  localparam logic [RW-1:0] c_confirm     = RW'(CONFIRM);

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    s2s3_q, s2s3_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] raw_cnt_q, raw_cnt_d;
  logic [1:0]    raw_ch_q, raw_ch_d;
  logic          raw_valid_q, raw_valid_d;
  logic [3:0]    match_q, match_d;
  logic [2:0]    prev_dec_q, prev_dec_d;
  logic [RW-1:0] run_q, run_d;
  logic [2:0]    color_q, color_d;
  logic          ambiguous_q, ambiguous_d;
  logic          frame_done_q, frame_done_d;
  logic          color_valid_q, color_valid_d;

  logic [CW-1:0] cnt_w;
  logic [CW-1:0] lo_w [4];
  logic [CW-1:0] hi_w [4];
  logic [2:0]    pop_w;
  logic [2:0]    dec_w;

  tcs_edge_counter #(.CW(CW)) u_edge_counter (
    .clk     (clk),
    .reset   (reset),
    .sens_in (sens_out),
    .clr     ((state_q == ST_IDLE) || (state_q == ST_SETTLE)),
    .en      (state_q == ST_COUNT),
    .cnt     (cnt_w)
  );

  // Unused channel slots read as zero so the channel index can stay 2 bits wide.
  for (genvar i = 0; i < 4; i++) begin : g_thr
    if (i < NCH) begin : g_used
      assign lo_w[i] = thr_lo[i*CW +: CW];
      assign hi_w[i] = thr_hi[i*CW +: CW];
    end else begin : g_unused
      assign lo_w[i] = '0;
      assign hi_w[i] = '0;
    end
  end

  always_comb begin
    pop_w = 3'($countones(match_q));
    dec_w = 3'd0;
    if (pop_w == 3'd1) begin
      for (int i = 0; i < 4; i++) begin
        if (match_q[i]) dec_w = 3'(i + 1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    timer_d       = '0;
    s2s3_d        = s2s3_q;
    raw_cnt_d     = raw_cnt_q;
    raw_ch_d      = raw_ch_q;
    raw_valid_d   = 1'b0;
    match_d       = match_q;
    prev_dec_d    = prev_dec_q;
    run_d         = run_q;
    color_d       = color_q;
    ambiguous_d   = ambiguous_q;
    frame_done_d  = 1'b0;
    color_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_SETTLE;
          ch_d    = CH_R;
          s2s3_d  = s2s3_of(CH_R);
        end
      end
      ST_SETTLE: begin
        if (timer_q == c_settle_last) state_d = ST_COUNT;
        else                          timer_d = timer_q + 1'b1;
      end
      ST_COUNT: begin
        if (timer_q == c_gate_last) state_d = ST_EVAL;
        else                        timer_d = timer_q + 1'b1;
      end
      ST_EVAL: begin
        match_d[ch_q] = (cnt_w >= lo_w[ch_q]) && (cnt_w <= hi_w[ch_q]);
        raw_cnt_d     = cnt_w;
        raw_ch_d      = ch_q;
        raw_valid_d   = 1'b1;
        if (ch_q == c_last_ch) begin
          state_d = ST_DECIDE;
        end else begin
          state_d = ST_SETTLE;
          ch_d    = ch_q + 1'b1;
          s2s3_d  = s2s3_of(ch_q + 1'b1);
        end
      end
      ST_DECIDE: begin
        ambiguous_d = (pop_w > 3'd1);
        // run_q == 0 means no history since reset, so the first frame never extends a run.
        if ((run_q != '0) && (dec_w == prev_dec_q))
          run_d = (run_q == c_confirm) ? run_q : run_q + 1'b1;
        else
          run_d = RW'(1);
        prev_dec_d = dec_w;
        if (run_d == c_confirm) begin
          color_d       = dec_w;
          color_valid_d = 1'b1;
        end
        frame_done_d = 1'b1;
        if (cont) begin
          state_d = ST_SETTLE;
          ch_d    = CH_R;
          s2s3_d  = s2s3_of(CH_R);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ch_q          <= CH_R;
      timer_q       <= '0;
      s2s3_q        <= 2'b10;
      busy_q        <= 1'b0;
      raw_cnt_q     <= '0;
      raw_ch_q      <= '0;
      raw_valid_q   <= 1'b0;
      match_q       <= '0;
      prev_dec_q    <= '0;
      run_q         <= '0;
      color_q       <= '0;
      ambiguous_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      color_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      timer_q       <= timer_d;
      s2s3_q        <= s2s3_d;
      busy_q        <= busy_d;
      raw_cnt_q     <= raw_cnt_d;
      raw_ch_q      <= raw_ch_d;
      raw_valid_q   <= raw_valid_d;
      match_q       <= match_d;
      prev_dec_q    <= prev_dec_d;
      run_q         <= run_d;
      color_q       <= color_d;
      ambiguous_q   <= ambiguous_d;
      frame_done_q  <= frame_done_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign s2          = s2s3_q[1];
  assign s3          = s2s3_q[0];
  assign busy        = busy_q;
  assign raw_cnt     = raw_cnt_q;
  assign raw_ch      = raw_ch_q;
  assign raw_valid   = raw_valid_q;
  assign color       = color_q;
  assign ambiguous   = ambiguous_q;
  assign frame_done  = frame_done_q;
  assign color_valid = color_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tcs_color_classifier.sv
// ============================================================================
// Module   : tb_tcs_color_classifier
// Purpose  : Directed self-checking bench for the TCS3200 colour classifier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tcs_color_classifier;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // main instance: default parameters
  logic start_m = 0, cont_m = 0, sens_m = 0;
  logic [26:0] lo_m, hi_m;
  logic s2_m, s3_m, busy_m, rv_m, amb_m, fd_m, cv_m;
  logic [8:0] rc_m;
  logic [1:0] rch_m;
  logic [2:0] col_m;

  // narrow-counter instance
  logic start_7 = 0, sens_7 = 0;
  logic [20:0] lo_7 = '0, hi_7 = {7'd127, 7'd127, 7'd127};
  logic s2_7, s3_7, busy_7, rv_7, amb_7, fd_7, cv_7;
  logic [6:0] rc_7;
  logic [1:0] rch_7;
  logic [2:0] col_7;

  // four-channel instance
  logic start_4 = 0, sens_4 = 0;
  logic [35:0] lo_4 = {9'd55, 9'd200, 9'd200, 9'd200};
  logic [35:0] hi_4 = {9'd65, 9'd250, 9'd250, 9'd250};
  logic s2_4, s3_4, busy_4, rv_4, amb_4, fd_4, cv_4;
  logic [8:0] rc_4;
  logic [1:0] rch_4;
  logic [2:0] col_4;

  tcs_color_classifier u_dut (
    .clk(clk), .reset(reset), .start(start_m), .cont(cont_m), .sens_out(sens_m),
    .thr_lo(lo_m), .thr_hi(hi_m), .s2(s2_m), .s3(s3_m), .busy(busy_m),
    .raw_cnt(rc_m), .raw_ch(rch_m), .raw_valid(rv_m), .color(col_m),
    .ambiguous(amb_m), .frame_done(fd_m), .color_valid(cv_m)
  );

  tcs_color_classifier #(.CW(7)) u_dut7 (
    .clk(clk), .reset(reset), .start(start_7), .cont(1'b0), .sens_out(sens_7),
    .thr_lo(lo_7), .thr_hi(hi_7), .s2(s2_7), .s3(s3_7), .busy(busy_7),
    .raw_cnt(rc_7), .raw_ch(rch_7), .raw_valid(rv_7), .color(col_7),
    .ambiguous(amb_7), .frame_done(fd_7), .color_valid(cv_7)
  );

  tcs_color_classifier #(.NCH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_4), .cont(1'b0), .sens_out(sens_4),
    .thr_lo(lo_4), .thr_hi(hi_4), .s2(s2_4), .s3(s3_4), .busy(busy_4),
    .raw_cnt(rc_4), .raw_ch(rch_4), .raw_valid(rv_4), .color(col_4),
    .ambiguous(amb_4), .frame_done(fd_4), .color_valid(cv_4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ch_of(input logic s2, input logic s3);
    case ({s2, s3})
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  // Periodic single-cycle-high sensor model; phase restarts when the period changes.
  task automatic step(input int p, inout int ph, inout int lp, output logic s);
    if (p != lp)          ph = 0;
    else if (ph >= p - 1) ph = 0;
    else                  ph++;
    lp = p;
    s  = (ph == 0);
  endtask

  int per_m[4] = '{3, 10, 10, 10};
  int per_7[4] = '{2, 2, 2, 2};
  int per_4[4] = '{3, 10, 10, 5};

  initial begin
    int ph_m = 0, lp_m = 0, ph_7 = 0, lp_7 = 0, ph_4 = 0, lp_4 = 0;
    forever begin
      @(negedge clk);
      step(per_m[ch_of(s2_m, s3_m)], ph_m, lp_m, sens_m);
      step(per_7[ch_of(s2_7, s3_7)], ph_7, lp_7, sens_7);
      step(per_4[ch_of(s2_4, s3_4)], ph_4, lp_4, sens_4);
    end
  end

  int raw_m[4], raw_7[4], raw_4[4];
  int n_fd_m = 0;
  logic [1:0] q4[$];
  initial begin
    logic [1:0] last4 = 2'b10;
    forever begin
      @(negedge clk);
      if (rv_m) raw_m[rch_m] = int'(rc_m);
      if (rv_7) raw_7[rch_7] = int'(rc_7);
      if (rv_4) raw_4[rch_4] = int'(rc_4);
      if (fd_m) n_fd_m++;
      if (busy_4 && ({s2_4, s3_4} != last4)) q4.push_back({s2_4, s3_4});
      last4 = {s2_4, s3_4};
    end
  end

  function automatic logic fd_sel(input int which);
    case (which)
      0:       return fd_m;
      1:       return fd_7;
      default: return fd_4;
    endcase
  endfunction

  task automatic wait_fd(input int which, output longint t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_sel(which) && n < 3000);
    if (!fd_sel(which)) chk("frame_done_timeout", 0, 1);
    t = longint'($time);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       start_m = 1'b1;
      1:       start_7 = 1'b1;
      default: start_4 = 1'b1;
    endcase
    @(negedge clk);
    start_m = 1'b0;
    start_7 = 1'b0;
    start_4 = 1'b0;
  endtask

  initial begin
    longint t1, t2, t3;
    int n, saved;
    lo_m = {9'd200, 9'd200, 9'd100};
    hi_m = {9'd250, 9'd250, 9'd120};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_s2", s2_m, 1);
    chk("rst_s3", s3_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_color", col_m, 0);
    chk("rst_raw_cnt", rc_m, 0);
    chk("rst_frame_done", fd_m, 0);

    // single-colour frames: confirmation needs two frames
    pulse(0);
    chk("busy_after_start", busy_m, 1);
    wait_fd(0, t1);
    chk("raw_r", raw_m[0], 100);
    chk("raw_g", raw_m[1], 30);
    chk("raw_b", raw_m[2], 30);
    chk("f1_color_valid", cv_m, 0);
    chk("f1_color", col_m, 0);
    chk("f1_ambiguous", amb_m, 0);
    pulse(0);
    wait_fd(0, t1);
    chk("f2_color_valid", cv_m, 1);
    chk("f2_color", col_m, 1);

    // two channels in window
    per_m = '{10, 10, 10, 10};
    lo_m = {9'd200, 9'd25, 9'd25};
    hi_m = {9'd250, 9'd35, 9'd35};
    pulse(0);
    wait_fd(0, t1);
    chk("amb_f1_ambiguous", amb_m, 1);
    chk("amb_f1_color_held", col_m, 1);
    chk("amb_f1_color_valid", cv_m, 0);
    pulse(0);
    wait_fd(0, t1);
    chk("amb_f2_color", col_m, 0);
    chk("amb_f2_color_valid", cv_m, 1);

    // saturation on the 7-bit instance
    pulse(1);
    wait_fd(1, t1);
    chk("sat_r", raw_7[0], 127);
    chk("sat_g", raw_7[1], 127);
    chk("sat_b", raw_7[2], 127);
    chk("sat_ambiguous", amb_7, 1);

    // continuous frames, ignored start pulses, cont dropped in frame 3
    per_m = '{3, 10, 10, 10};
    lo_m = {9'd200, 9'd200, 9'd100};
    hi_m = {9'd250, 9'd250, 9'd120};
    @(negedge clk);
    cont_m = 1'b1;
    repeat (20) @(negedge clk);
    pulse(0);
    repeat (300) @(negedge clk);
    pulse(0);
    wait_fd(0, t1);
    chk("cont_f1_busy", busy_m, 1);
    wait_fd(0, t2);
    repeat (200) @(negedge clk);
    cont_m = 1'b0;
    wait_fd(0, t3);
    chk("cont_spacing_12", int'((t2 - t1) / 10), 916);
    chk("cont_spacing_23", int'((t3 - t2) / 10), 916);
    chk("cont_f3_idle", busy_m, 0);
    chk("cont_f3_color", col_m, 1);
    chk("cont_f3_color_valid", cv_m, 1);
    saved = n_fd_m;
    repeat (1000) @(negedge clk);
    chk("cont_no_extra_frame", n_fd_m, saved);

    // reset in the middle of the green count window
    pulse(0);
    n = 0;
    while (!(s2_m && s3_m) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_green", {s2_m, s3_m}, 2'b11);
    repeat (100) @(negedge clk);
    saved = n_fd_m;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy_m, 0);
    chk("midrst_s2", s2_m, 1);
    chk("midrst_s3", s3_m, 0);
    chk("midrst_color", col_m, 0);
    repeat (1000) @(negedge clk);
    chk("midrst_no_frame_done", n_fd_m, saved);

    // four channels: filter order and clear-only match
    q4.delete();
    pulse(2);
    wait_fd(2, t1);
    chk("nch4_seq_len", q4.size(), 4);
    if (q4.size() == 4) begin
      chk("nch4_seq0", q4[0], 2'b00);
      chk("nch4_seq1", q4[1], 2'b11);
      chk("nch4_seq2", q4[2], 2'b01);
      chk("nch4_seq3", q4[3], 2'b10);
    end
    chk("nch4_raw_c", raw_4[3], 60);
    pulse(2);
    wait_fd(2, t1);
    chk("nch4_color", col_4, 4);
    chk("nch4_color_valid", cv_4, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
